// File: rtl/stuff_tx.sv
// Bit-stuffing serial transmitter: MSB-first words, complement bit inserted after MAX_RUN equal bits.
// Optional even-parity bit appended after the LSB when STUFF_TX_PARITY_EN is defined.
module stuff_tx #(
  parameter int WIDTH   = 8,
  parameter int MAX_RUN = 3
) (
  input  logic             clk,
  input  logic             RESET,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  output logic             ready,
  output logic             out,
  output logic             out_valid,
  output logic             stuffing
);

`ifdef STUFF_TX_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam int CW = $clog2(NBITS + 1);
  localparam int RW = $clog2(MAX_RUN + 1);

  logic [NBITS-1:0] shreg;
  logic [CW-1:0]    bits_left;
  logic             run_bit;
  logic [RW-1:0]    run_cnt;
  logic [NBITS-1:0] word;
  logic             stuff_due;
  logic             next_bit;
  logic             same_run;

`ifdef STUFF_TX_PARITY_EN
  assign word = {data_in, ^data_in};
`else
  assign word = data_in;
`endif

  assign stuff_due = out_valid && (run_cnt == RW'(MAX_RUN));
  assign ready     = (bits_left == '0) && !stuff_due;

  // A fresh word from IDLE starts a new run; otherwise history is continuous.
  always_comb begin
    next_bit = (bits_left != '0) ? shreg[NBITS-1] : word[NBITS-1];
    same_run = out_valid && (next_bit == run_bit);
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      shreg     <= '0;
      bits_left <= '0;
      run_bit   <= 1'b0;
      run_cnt   <= '0;
      out       <= 1'b0;
      out_valid <= 1'b0;
      stuffing  <= 1'b0;
    end else if (stuff_due) begin
      out       <= ~run_bit;
      run_bit   <= ~run_bit;
      run_cnt   <= RW'(1);
      out_valid <= 1'b1;
      stuffing  <= 1'b1;
    end else if (bits_left != '0 || load) begin
      out       <= next_bit;
      run_bit   <= next_bit;
      run_cnt   <= same_run ? run_cnt + RW'(1) : RW'(1);
      out_valid <= 1'b1;
      stuffing  <= 1'b0;
      if (bits_left != '0) begin
        shreg     <= shreg << 1;
        bits_left <= bits_left - CW'(1);
      end else begin
        shreg     <= word << 1;
        bits_left <= CW'(NBITS - 1);
      end
    end else begin
      out       <= 1'b0;
      out_valid <= 1'b0;
      stuffing  <= 1'b0;
      run_cnt   <= '0;
    end
  end

endmodule

// File: tb/tb_stuff_tx.sv
// Self-checking bench for stuff_tx (WIDTH=8, MAX_RUN=3, parity off) against a bit-stream model.
module tb_stuff_tx;
  localparam int WIDTH   = 8;
  localparam int MAX_RUN = 3;

  logic             clk = 1'b0;
  logic             RESET;
  logic             load;
  logic [WIDTH-1:0] data_in;
  logic             ready;
  logic             out;
  logic             out_valid;
  logic             stuffing;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  stuff_tx #(.WIDTH(WIDTH), .MAX_RUN(MAX_RUN)) dut (
    .clk(clk), .RESET(RESET), .load(load), .data_in(data_in),
    .ready(ready), .out(out), .out_valid(out_valid), .stuffing(stuffing)
  );

  // Per-cycle line samples {valid, bit, stuff, ready}
  logic             mon_en = 1'b0;
  logic [3:0]       mon_q[$];
  always @(negedge clk) if (mon_en) mon_q.push_back({out_valid, out, stuffing, ready});

  logic [WIDTH-1:0] wq[$];     // words of one burst
  logic [2:0]       exp_q[$];  // expected {bit, stuff, ready} per valid cycle
  logic [2:0]       obs_q[$];  // observed {bit, stuff, ready} per valid cycle

  // Reference: walk the concatenated data bits, inserting a complement bit whenever
  // the run already has MAX_RUN equal bits; ready is high once the current word's
  // data bits are all out and no stuff bit is owed.
  task automatic build_model();
    logic rb;
    int   rn;
    logic b;
    logic [WIDTH-1:0] w;
    exp_q.delete();
    rb = 1'b0;
    rn = 0;
    for (int wi = 0; wi < wq.size(); wi++) begin
      w = wq[wi];
      for (int i = WIDTH - 1; i >= 0; i--) begin
        b = w[i];
        if (rn == MAX_RUN) begin
          exp_q.push_back({~rb, 1'b1, (i == WIDTH - 1) ? 1'b1 : 1'b0});
          rb = ~rb;
          rn = 1;
        end
        if (rn > 0 && b == rb) rn++;
        else begin
          rb = b;
          rn = 1;
        end
        exp_q.push_back({b, 1'b0, (i == 0 && rn != MAX_RUN) ? 1'b1 : 1'b0});
      end
    end
    if (rn == MAX_RUN) exp_q.push_back({~rb, 1'b1, 1'b1});
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic finish_burst(input string name);
    bit ok;
    bit idle_bad;
    int i;
    int bad_idx;
    int run;
    int max_run;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (!out_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s idle_timeout: out_valid=%b required 0", name, out_valid);
    end
    @(negedge clk);
    @(posedge clk);
    #1;
    mon_en = 1'b0;
    obs_q.delete();
    i = 0;
    while (i < mon_q.size() && mon_q[i][3] == 1'b0) i++;
    while (i < mon_q.size() && mon_q[i][3] == 1'b1) begin
      obs_q.push_back(mon_q[i][2:0]);
      i++;
    end
    idle_bad = 1'b0;
    while (i < mon_q.size()) begin
      if (mon_q[i][3] || mon_q[i][2] || mon_q[i][1]) idle_bad = 1'b1;
      i++;
    end
    tests++;
    if (idle_bad) begin
      fails++;
      $display("FAIL %s gap_or_idle: valid/out/stuffing activity after the burst ended, required contiguous burst then idle zeros", name);
    end
    tests++;
    if (obs_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL %s length: got %0d cycles required %0d", name, obs_q.size(), exp_q.size());
    end
    bad_idx = -1;
    for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++)
      if (obs_q[k] !== exp_q[k] && bad_idx < 0) bad_idx = k;
    tests++;
    if (bad_idx >= 0) begin
      fails++;
      $display("FAIL %s stream: cycle %0d {bit,stuff,ready}=%b required %b",
               name, bad_idx + 1, obs_q[bad_idx], exp_q[bad_idx]);
    end
    run = 0;
    max_run = 0;
    for (int k = 0; k < obs_q.size(); k++) begin
      if (k > 0 && obs_q[k][2] == obs_q[k-1][2]) run++;
      else run = 1;
      if (run > max_run) max_run = run;
    end
    tests++;
    if (max_run > MAX_RUN) begin
      fails++;
      $display("FAIL %s max_run: got %0d required <= %0d", name, max_run, MAX_RUN);
    end
  endtask

  // Sends every word in wq with load held high, then checks the whole burst.
  task automatic run_burst(input string name);
    bit ok;
    logic [WIDTH-1:0] w;
    build_model();
    mon_q.delete();
    mon_en = 1'b1;
    for (int wi = 0; wi < wq.size(); wi++) begin
      w       = wq[wi];
      data_in = w;
      load    = 1'b1;
      wait_ready(ok);
      tests++;
      if (!ok) begin
        fails++;
        $display("FAIL %s ready_timeout: word %0d ready=%b required 1", name, wi, ready);
        load   = 1'b0;
        mon_en = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      if (wi == 0) begin
        tests++;
        if (out_valid !== 1'b1 || out !== w[WIDTH-1]) begin
          fails++;
          $display("FAIL %s latency: out_valid=%b out=%b required 1 and %b",
                   name, out_valid, out, w[WIDTH-1]);
        end
      end
    end
    load    = 1'b0;
    data_in = WIDTH'($urandom);
    finish_burst(name);
  endtask

  task automatic check_pattern(input string name, input logic [31:0] bits,
                               input logic [31:0] smask, input logic [31:0] rmask, input int len);
    logic [31:0] ob;
    logic [31:0] os;
    logic [31:0] orr;
    ob  = '0;
    os  = '0;
    orr = '0;
    for (int k = 0; k < obs_q.size() && k < len; k++) begin
      ob[len-1-k]  = obs_q[k][2];
      os[len-1-k]  = obs_q[k][1];
      orr[len-1-k] = obs_q[k][0];
    end
    tests++;
    if (obs_q.size() != len || ob !== bits || os !== smask || orr !== rmask) begin
      fails++;
      $display("FAIL %s pattern: len=%0d out=%b stuffing=%b ready=%b required len=%0d out=%b stuffing=%b ready=%b",
               name, obs_q.size(), ob, os, orr, len, bits, smask, rmask);
    end
  endtask

  task automatic test_reset();
    RESET   = 1'b1;
    load    = 1'b0;
    data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    RESET = 1'b0;
    tests++;
    if (out !== 1'b0 || out_valid !== 1'b0 || stuffing !== 1'b0 || ready !== 1'b1) begin
      fails++;
      $display("FAIL reset: out=%b out_valid=%b stuffing=%b ready=%b required 0 0 0 1",
               out, out_valid, stuffing, ready);
    end
  endtask

  task automatic test_directed();
    wq = '{8'hA5};
    run_burst("a5");
    check_pattern("a5", 32'b10100101, 32'b0, 32'b00000001, 8);
    wq = '{8'h00};
    run_burst("h00");
    check_pattern("h00", 32'b0001000100, 32'b0001000100, 32'b0000000001, 10);
    wq = '{8'hFF};
    run_burst("hff");
    check_pattern("hff", 32'b1110111011, 32'b0001000100, 32'b0000000001, 10);
  endtask

  task automatic test_back_to_back();
    wq = '{8'h0F, 8'hF0};
    run_burst("b2b_0f_f0");
    check_pattern("b2b_0f_f0", 32'b00010111011101100010, 32'b00010000100010000010,
                  32'b00000000010000000001, 20);
    for (int r = 0; r < 8; r++) begin
      wq.delete();
      for (int k = 0; k < int'($urandom_range(2, 4)); k++) begin
        // Mix in long-run words so boundary stuffing is exercised often.
        case ($urandom_range(0, 3))
          0:       wq.push_back(8'h00);
          1:       wq.push_back(8'hFF);
          default: wq.push_back(WIDTH'($urandom));
        endcase
      end
      run_burst($sformatf("b2b_rand%0d", r));
    end
  endtask

  task automatic test_random_single();
    for (int r = 0; r < 12; r++) begin
      wq = '{WIDTH'($urandom)};
      run_burst($sformatf("single_rand%0d_%02h", r, wq[0]));
    end
  endtask

  task automatic test_ignore_busy_load();
    bit ok;
    wq = '{8'h00};
    build_model();
    mon_q.delete();
    mon_en  = 1'b1;
    data_in = 8'h00;
    load    = 1'b1;
    wait_ready(ok);
    @(posedge clk);
    #1;
    data_in = 8'hFF;
    repeat (4) @(posedge clk);
    #1;
    load = 1'b0;
    finish_burst("ignore_busy");
  endtask

  task automatic test_reset_midword();
    bit ok;
    data_in = 8'h00;
    load    = 1'b1;
    wait_ready(ok);
    @(posedge clk);
    #1;
    load = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    RESET = 1'b1;
    @(posedge clk);
    #1;
    RESET = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || ready !== 1'b1 || out !== 1'b0 || stuffing !== 1'b0) begin
      fails++;
      $display("FAIL reset_midword: out_valid=%b ready=%b out=%b stuffing=%b required 0 1 0 0",
               out_valid, ready, out, stuffing);
    end
    wq = '{8'hFF};
    run_burst("after_reset_ff");
    check_pattern("after_reset_ff", 32'b1110111011, 32'b0001000100, 32'b0000000001, 10);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random_single();
    test_ignore_busy_load();
    test_reset_midword();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/stuff_tx.md
# stuff_tx

Serial bit-stuffing transmitter. Each accepted parallel word is serialized MSB first. After every run of MAX_RUN identical output bits, one complement "stuff" bit is inserted. With MAX_RUN=3, no run of four identical bits ever appears on the line, so the run-of-four sequence detector on the receive side never fires on legal traffic. It sits at the transmit end of the serial test link, driving the line that the detector samples.

## Interface
- WIDTH, 8: data word width, ≥2.
- MAX_RUN, 3: longest run of identical bits allowed on `out`, ≥2.
- clk  in  1: clock; all state updates on rising edge.
- RESET  in  1: reset, synchronous, active-high.
- load  in  1: word-valid strobe; accepted on an edge where `load && ready`.
- data_in  in  WIDTH: parallel word, sampled on acceptance.
- ready  out  1: combinational; block can accept a word this cycle.
- out  out  1: registered serial bit.
- out_valid  out  1: registered; `out` carries a data, parity or stuff bit.
- stuffing  out  1: registered; current `out` bit is a stuff bit.

## Operation
- Internal registers:
  - `shreg` (WIDTH): shift register.
  - `bits_left`: count of bits remaining in the current word.
  - `run_bit`, `run_cnt`: value and length of the current run.
- States, decoded from the registers:
  - IDLE: `out_valid`=0.
  - DATA: `out` is a data or parity bit.
  - STUFF: `out` is a stuff bit.
- Next-bit priority, evaluated at each edge:
  1. `out_valid && run_cnt==MAX_RUN`: emit ~`run_bit` as a stuff bit; `run_bit`<=~`run_bit`; `run_cnt`<=1; `stuffing`<=1.
  2. Else if `bits_left`>0: emit the next data bit. If it equals `run_bit`, increment `run_cnt`; otherwise set `run_cnt`<=1 and `run_bit`<=bit.
  3. Else if `load && ready`: capture `data_in` and emit its MSB, applying the same run update as rule 2. History is continuous when the previous cycle was valid; from IDLE, `run_cnt`<=1.
  4. Else go to IDLE: `out_valid`<=0, `out`<=0, `run_cnt`<=0.
- `ready` = (`bits_left`==0) && !(`out_valid` && `run_cnt`==MAX_RUN). It is high in IDLE, and high during the final bit of a word when no stuff bit is pending.
- Back-to-back words produce a gap-free stream. Run history carries across the word boundary, so the first bits of the next word may trigger stuffing.
- A trailing stuff bit owed after a word's last bit is always emitted before the next word or IDLE.
- `load` while `ready`=0 is ignored. No buffering; the source must hold `load` until `ready`.
- `run_cnt` never exceeds MAX_RUN, and MAX_RUN+1 identical bits never appear while `out_valid`=1.

## Timing
- Reset values: `out`=0, `out_valid`=0, `stuffing`=0, `bits_left`=0, `run_cnt`=0. `ready`=1 in the first cycle after reset.
- RESET mid-word aborts the word immediately. The next cycle is IDLE with history cleared, and the partial word is lost.
- Latency: word accepted at edge k; its MSB is on `out` with `out_valid`=1 from edge k to edge k+1.
- Output length per word: WIDTH bits plus the number of stuff bits, one bit per cycle.
- `stuffing` is asserted exactly in cycles where `out` is a stuff bit.

## Configuration
- STUFF_TX_PARITY_EN defined:
  - An even-parity bit over the WIDTH data bits is appended after the LSB.
  - The parity bit is counted as bit WIDTH+1 and takes part in run tracking and stuffing exactly like a data bit.
  - `ready` asserts only during the parity-bit cycle.
- Undefined: no parity bit; words are WIDTH bits plus stuff bits only.

## Test plan
All cases use WIDTH=8, MAX_RUN=3, parity off.
- Reset: RESET high 2 cycles → `out`=0, `out_valid`=0, `stuffing`=0, `ready`=1.
- Load 8'hA5 from IDLE → `out` = 1,0,1,0,0,1,0,1 over 8 cycles, `stuffing` never high. `ready` is high in the 8th cycle; IDLE follows.
- Load 8'h00 → `out` = 0,0,0,1,0,0,0,1,0,0 over 10 cycles, with `stuffing`=1 in cycles 4 and 8.
- Load 8'hFF → `out` = 1,1,1,0,1,1,1,0,1,1 over 10 cycles.
- Back-to-back 8'h0F then 8'hF0, `load` held high → 20 contiguous valid cycles: 0,0,0,1,0,1,1,1,0,1 then 1,1,0,1,1,0,0,0,1,0. No run longer than 3 anywhere, including across the boundary.
- RESET in cycle 3 of 8'h00 → next cycle `out_valid`=0, `ready`=1. A following 8'hFF restarts with fresh history and gives the 10-bit pattern above. With parity on, 8'h01 gives 0,0,0,1,0,0,0,1,0,1,1 (11 cycles).
